// File: rtl/display_pkg.sv
// Shared display types: BCD digit/number types, converter FSM states and
// the leading-zero enable helper used by the formatter and the display driver.
package display_pkg;

  localparam int DISPLAY_DIGITS = 4;
  localparam int BCD_MAX        = 9999;

  typedef logic [3:0]                    bcd_digit_t;
  typedef logic [4*DISPLAY_DIGITS-1:0]   bcd_number_t;

  localparam bcd_number_t BCD_SATURATED = 16'h9999;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT
  } state_e;

  // A digit is lit when it or any more significant digit is nonzero; the
  // ones digit is always lit so zero shows as a single "0".
  function automatic logic [DISPLAY_DIGITS-1:0] lz_enables(input bcd_number_t n);
    logic [DISPLAY_DIGITS-1:0] en;
    logic                      any_nz;
    en     = '0;
    any_nz = 1'b0;
    for (int i = DISPLAY_DIGITS - 1; i >= 0; i--) begin
      any_nz = any_nz | (n[4*i +: 4] != 4'd0);
      en[i]  = any_nz;
    end
    en[0] = 1'b1;
    return en;
  endfunction

endpackage

// File: rtl/bin_to_bcd_formatter_bcd_add3.sv
// Double-dabble nibble corrector: digits of 5..9 get +3 before the shift.
// Purely combinational, no latency, no flow control.
module bcd_add3
  import display_pkg::*;
(
  input  bcd_digit_t digit_i,
  output bcd_digit_t digit_o
);

  always_comb begin
    digit_o = digit_i;
    if (digit_i >= 4'd5) begin
      digit_o = digit_i + 4'd3;
    end
  end

endmodule

// File: rtl/bin_to_bcd_formatter.sv
// Serial binary->BCD converter feeding the 4-digit display; BIN_TO_BCD_LZ_BLANK_EN enables leading-zero blanking.
// Latency BIN_WIDTH+2 cycles from accept to update; in_ready low while busy, in_valid then ignored.
module bin_to_bcd_formatter
  import display_pkg::*;
#(
  parameter int BIN_WIDTH = 16,
  parameter int MAX_VALUE = BCD_MAX
)
(
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [BIN_WIDTH-1:0]      in_value,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [15:0]               number,
  output logic [DISPLAY_DIGITS-1:0] digit_enables,
  output logic                      overflow,
  output logic                      update
);

  localparam int          CNT_W = $clog2(BIN_WIDTH);
  localparam logic [31:0] MAX_U = MAX_VALUE;

  state_e                    state_q;
  logic [BIN_WIDTH-1:0]      shift_q;
  logic [BIN_WIDTH-1:0]      shift_d;
  bcd_number_t               bcd_q;
  bcd_number_t               bcd_d;
  bcd_number_t               bcd_adj;
  logic [CNT_W-1:0]          cnt_q;
  logic                      sat_q;
  logic                      sat_d;
  bcd_number_t               number_q;
  bcd_number_t               number_d;
  logic [DISPLAY_DIGITS-1:0] en_q;
  logic [DISPLAY_DIGITS-1:0] en_d;
  logic                      ovf_q;
  logic                      upd_q;
  logic                      rdy_q;

  // Constant-folds to 0 for narrow inputs that can never exceed the limit.
  assign sat_d = (32'(in_value) > MAX_U);

  for (genvar g = 0; g < DISPLAY_DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .digit_i (bcd_q[4*g +: 4]),
      .digit_o (bcd_adj[4*g +: 4])
    );
  end

  logic [16+BIN_WIDTH-1:0] dabble_d;
  assign dabble_d = {bcd_adj, shift_q} << 1;
  assign bcd_d    = dabble_d[16+BIN_WIDTH-1 -: 16];
  assign shift_d  = dabble_d[BIN_WIDTH-1:0];

  assign number_d = sat_q ? BCD_SATURATED : bcd_q;

`ifdef BIN_TO_BCD_LZ_BLANK_EN
  assign en_d = lz_enables(number_d);
`else
  assign en_d = '1;
`endif

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      bcd_q    <= '0;
      cnt_q    <= '0;
      sat_q    <= 1'b0;
      number_q <= '0;
      en_q     <= '0;
      ovf_q    <= 1'b0;
      upd_q    <= 1'b0;
      rdy_q    <= 1'b1;
    end else begin
      upd_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (in_valid && rdy_q) begin
            shift_q <= in_value;
            bcd_q   <= '0;
            sat_q   <= sat_d;
            cnt_q   <= CNT_W'(BIN_WIDTH - 1);
            rdy_q   <= 1'b0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          shift_q <= shift_d;
          bcd_q   <= bcd_d;
          cnt_q   <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) begin
            state_q <= COMMIT;
          end
        end
        COMMIT: begin
          number_q <= number_d;
          en_q     <= en_d;
          ovf_q    <= sat_q;
          upd_q    <= 1'b1;
          rdy_q    <= 1'b1;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          rdy_q   <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready      = rdy_q;
  assign number        = number_q;
  assign digit_enables = en_q;
  assign overflow      = ovf_q;
  assign update        = upd_q;

endmodule

// File: tb/tb_bin_to_bcd_formatter.sv
// Bench for bin_to_bcd_formatter at BIN_WIDTH 16 and 8: vector table, random values,
// held in_valid, reset mid-conversion.
module tb_bin_to_bcd_formatter;

`ifdef BIN_TO_BCD_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;

  logic [15:0] in_value = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] number;
  logic [3:0]  digit_enables;
  logic        overflow;
  logic        update;

  logic [7:0]  in_value8 = '0;
  logic        in_valid8 = 1'b0;
  logic        in_ready8;
  logic [15:0] number8;
  logic [3:0]  digit_enables8;
  logic        overflow8;
  logic        update8;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  bin_to_bcd_formatter #(.BIN_WIDTH(16)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_value      (in_value),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .number        (number),
    .digit_enables (digit_enables),
    .overflow      (overflow),
    .update        (update)
  );

  bin_to_bcd_formatter #(.BIN_WIDTH(8)) dut8 (
    .clock         (clock),
    .reset_n       (reset_n),
    .in_value      (in_value8),
    .in_valid      (in_valid8),
    .in_ready      (in_ready8),
    .number        (number8),
    .digit_enables (digit_enables8),
    .overflow      (overflow8),
    .update        (update8)
  );

  // Reference: decimal digits by plain division, saturating above 9999.
  function automatic logic [15:0] ref_num(input int v);
    if (v > 9999) return 16'h9999;
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  function automatic logic [3:0] ref_en(input int v);
    if (!LZ)      return 4'b1111;
    if (v >= 1000) return 4'b1111;
    if (v >= 100)  return 4'b0111;
    if (v >= 10)   return 4'b0011;
    return 4'b0001;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic get(input bit sel8, output logic rdy, output logic [15:0] num,
                     output logic [3:0] en, output logic ovf, output logic upd);
    if (sel8) begin
      rdy = in_ready8; num = number8; en = digit_enables8; ovf = overflow8; upd = update8;
    end else begin
      rdy = in_ready;  num = number;  en = digit_enables;  ovf = overflow;  upd = update;
    end
  endtask

  task automatic convert(input bit sel8, input int v, input logic [15:0] e_num,
                         input logic [3:0] e_en, input logic e_ovf, input string tag);
    logic        rdy, ovf, upd;
    logic [15:0] num;
    logic [3:0]  en;
    int          n, lat, bw;
    bw = sel8 ? 8 : 16;
    n  = 0;
    get(sel8, rdy, num, en, ovf, upd);
    while (!rdy && n < 60) begin
      @(posedge clock); #1;
      get(sel8, rdy, num, en, ovf, upd);
      n++;
    end
    @(negedge clock);
    if (sel8) begin in_value8 = 8'(v); in_valid8 = 1'b1; end
    else      begin in_value  = 16'(v); in_valid  = 1'b1; end
    @(posedge clock); #1;
    in_valid  = 1'b0;
    in_valid8 = 1'b0;
    get(sel8, rdy, num, en, ovf, upd);
    check({tag, " busy"}, 32'(rdy), 32'(0));
    lat = 0;
    n   = 1;
    while (n < 40 && lat == 0) begin
      @(posedge clock); #1;
      n++;
      get(sel8, rdy, num, en, ovf, upd);
      if (upd) lat = n;
    end
    check({tag, " latency"}, 32'(lat), 32'(bw + 2));
    check({tag, " number"}, 32'(num), 32'(e_num));
    check({tag, " enables"}, 32'(en), 32'(e_en));
    check({tag, " overflow"}, 32'(ovf), 32'(e_ovf));
    check({tag, " ready"}, 32'(rdy), 32'(1));
    @(posedge clock); #1;
    get(sel8, rdy, num, en, ovf, upd);
    check({tag, " pulse width"}, 32'(upd), 32'(0));
    check({tag, " hold"}, 32'(num), 32'(e_num));
  endtask

  typedef struct {
    int          val;
    logic [15:0] num;
    logic [3:0]  en;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          v, c, last, pulses, unstable, n;
    bit          pre_rdy;
    logic [15:0] held;
    logic [3:0]  held_en;
    int          q[$];

    vecs[0] = '{1234,  16'h1234, 4'b1111,                   1'b0};
    vecs[1] = '{7,     16'h0007, LZ ? 4'b0001 : 4'b1111,    1'b0};
    vecs[2] = '{0,     16'h0000, LZ ? 4'b0001 : 4'b1111,    1'b0};
    vecs[3] = '{120,   16'h0120, LZ ? 4'b0111 : 4'b1111,    1'b0};
    vecs[4] = '{9999,  16'h9999, 4'b1111,                   1'b0};
    vecs[5] = '{10000, 16'h9999, 4'b1111,                   1'b1};
    vecs[6] = '{65535, 16'h9999, 4'b1111,                   1'b1};
    vecs[7] = '{1000,  16'h1000, 4'b1111,                   1'b0};
    vecs[8] = '{10,    16'h0010, LZ ? 4'b0011 : 4'b1111,    1'b0};
    vecs[9] = '{8421,  16'h8421, 4'b1111,                   1'b0};

    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("reset number", 32'(number), 32'(0));
    check("reset enables", 32'(digit_enables), 32'(0));
    check("reset overflow", 32'(overflow), 32'(0));
    check("reset update", 32'(update), 32'(0));
    check("reset ready", 32'(in_ready), 32'(1));
    check("reset ready w8", 32'(in_ready8), 32'(1));
    @(negedge clock);
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      convert(1'b0, vecs[i].val, vecs[i].num, vecs[i].en, vecs[i].ovf, $sformatf("vec%0d", vecs[i].val));
    end

    for (int i = 0; i < 20; i++) begin
      v = int'($urandom_range(0, 65535));
      convert(1'b0, v, ref_num(v), ref_en(v), v > 9999, $sformatf("rnd%0d", v));
    end

    // in_valid held high with a new value every cycle
    last = -1; pulses = 0; unstable = 0; held = '0; held_en = '0;
    for (c = 0; c < 80; c++) begin
      @(negedge clock);
      in_value = 16'($urandom);
      in_valid = 1'b1;
      pre_rdy  = in_ready;
      @(posedge clock);
      if (pre_rdy) q.push_back(int'(in_value));
      #1;
      if (update) begin
        pulses++;
        if (q.size() == 0) check("hold queue", 32'(0), 32'(1));
        else begin
          v = q.pop_front();
          check("hold number", 32'(number), 32'(ref_num(v)));
          check("hold overflow", 32'(overflow), 32'(v > 9999));
        end
        if (last >= 0) check("hold gap", 32'(c - last), 32'(18));
        last = c; held = number; held_en = digit_enables;
      end else if (last >= 0 && (number !== held || digit_enables !== held_en)) begin
        unstable++;
      end
    end
    @(negedge clock);
    in_valid = 1'b0;
    check("hold pulses", 32'(pulses), 32'(4));
    check("hold unstable", 32'(unstable), 32'(0));
    n = 0;
    while (!update && n < 40) begin @(posedge clock); #1; n++; end
    if (q.size() == 0) check("hold drain queue", 32'(0), 32'(1));
    else check("hold drain", 32'(number), 32'(ref_num(q.pop_front())));
    check("hold drain pulse", 32'(update), 32'(1));

    // reset during SHIFT cycle 5
    convert(1'b0, 1234, 16'h1234, 4'b1111, 1'b0, "pre-reset");
    @(negedge clock);
    in_value = 16'd4321;
    in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    @(posedge clock); #1;
    check("midreset number", 32'(number), 32'(0));
    check("midreset enables", 32'(digit_enables), 32'(0));
    check("midreset overflow", 32'(overflow), 32'(0));
    check("midreset ready", 32'(in_ready), 32'(1));
    check("midreset update", 32'(update), 32'(0));
    @(negedge clock);
    reset_n = 1'b1;
    pulses = 0;
    repeat (30) begin @(posedge clock); #1; if (update) pulses++; end
    check("midreset no pulse", 32'(pulses), 32'(0));
    convert(1'b0, 55, 16'h0055, LZ ? 4'b0011 : 4'b1111, 1'b0, "post-reset 55");

    convert(1'b1, 255, 16'h0255, LZ ? 4'b0111 : 4'b1111, 1'b0, "w8 255");
    for (int i = 0; i < 5; i++) begin
      v = int'($urandom_range(0, 255));
      convert(1'b1, v, ref_num(v), ref_en(v), 1'b0, $sformatf("w8 rnd%0d", v));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
